// File: rtl/hist_bin_scheduler_pkg.sv
// Shared types and constants for the histogram bin scheduler.
// A frame walks through IDLE -> LOAD -> SCAN -> DONE.
package hist_bin_scheduler_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int SAMPLES_PER_GRP = 4;
  localparam int GROUP_W         = SAMPLE_W * SAMPLES_PER_GRP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/hist_bin_scheduler_count.sv
// Combinational bin counter: how many of the four samples fall inside [lo, hi].
// An inverted range (lo > hi) can never match, so it naturally yields zero.
module hist_bin_count
  import hist_bin_scheduler_pkg::*;
(
  input  logic [GROUP_W-1:0]  samples,
  input  logic [SAMPLE_W-1:0] lo,
  input  logic [SAMPLE_W-1:0] hi,
  output logic [2:0]          count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < SAMPLES_PER_GRP; i++) begin
      if ((samples[i*SAMPLE_W +: SAMPLE_W] >= lo) && (samples[i*SAMPLE_W +: SAMPLE_W] <= hi))
        count = count + 3'd1;
    end
  end

endmodule

// File: rtl/hist_bin_scheduler.sv
// Histogram scheduler: accepts 4-sample groups and time-shares one bin counter
// across all bins, spending one SCAN cycle per bin for every accepted group.
module hist_bin_scheduler
  import hist_bin_scheduler_pkg::*;
#(
  parameter int NUM_BINS = 4,
  parameter int CNT_W    = 16,
  parameter int GRP_W    = 8,
  localparam int ADDR_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [SAMPLE_W-1:0] cfg_lo,
  input  logic [SAMPLE_W-1:0] cfg_hi,
  input  logic                start,
  input  logic [GRP_W-1:0]    num_groups,
  input  logic                s_valid,
  input  logic [GROUP_W-1:0]  s_data,
  output logic                s_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [CNT_W-1:0]    rd_count,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W+2:0] ACC_MAX = {3'b000, {CNT_W{1'b1}}};

  state_t              state, state_nxt;
  logic [SAMPLE_W-1:0] bound_lo [NUM_BINS];
  logic [SAMPLE_W-1:0] bound_hi [NUM_BINS];
  logic [CNT_W-1:0]    acc      [NUM_BINS];
  logic [GRP_W-1:0]    grp_cnt, grp_target;
  logic [ADDR_W-1:0]   bin_idx;
  logic [GROUP_W-1:0]  samples_p0;
  logic [2:0]          bin_hits;
  logic                last_bin, last_grp, cfg_open;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W+2:0] sum;
    sum = {3'b000, a} + {{CNT_W{1'b0}}, b};
    return (sum > ACC_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign last_bin = (bin_idx == ADDR_W'(NUM_BINS - 1));
  assign last_grp = ((grp_cnt + GRP_W'(1)) == grp_target);
  assign cfg_open = (state == IDLE) || (state == DONE);
  assign rd_count = acc[rd_addr];

  hist_bin_count u_count (
    .samples (samples_p0),
    .lo      (bound_lo[bin_idx]),
    .hi      (bound_hi[bin_idx]),
    .count   (bin_hits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = (num_groups == '0) ? DONE : LOAD;
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last_bin) state_nxt = last_grp ? DONE : LOAD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: group capture on the LOAD handshake
  always_ff @(posedge clk) begin
    if ((state == LOAD) && s_valid) samples_p0 <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        acc[b]      <= '0;
        bound_lo[b] <= '0;
        bound_hi[b] <= '0;
      end
      grp_cnt    <= '0;
      grp_target <= '0;
      bin_idx    <= '0;
    end else begin
      if (cfg_we && cfg_open) begin
        bound_lo[cfg_addr] <= cfg_lo;
        bound_hi[cfg_addr] <= cfg_hi;
      end
      case (state)
        IDLE: if (start) begin
          for (int b = 0; b < NUM_BINS; b++) acc[b] <= '0;
          grp_cnt    <= '0;
          grp_target <= num_groups;
        end
        LOAD: if (s_valid) bin_idx <= '0;
        // Stage p1: one bin evaluated and accumulated per cycle
        SCAN: begin
          acc[bin_idx] <= sat_add(acc[bin_idx], bin_hits);
          bin_idx      <= bin_idx + ADDR_W'(1);
          if (last_bin) grp_cnt <= grp_cnt + GRP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hist_bin_scheduler.md
HIST_BIN_SCHEDULER -- requirements
Module: hist_bin_scheduler

Interface
REQ-001 Parameter NUM_BINS, default 4, number of histogram bins.
REQ-002 Parameter CNT_W, default 16, width of each bin accumulator.
REQ-003 Parameter GRP_W, default 8, width of the group-count field.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cfg_we  in  1  bin bound write strobe.
REQ-007 cfg_addr  in  log2(NUM_BINS)  bin index to write.
REQ-008 cfg_lo  in  8  inclusive lower bound.
REQ-009 cfg_hi  in  8  inclusive upper bound.
REQ-010 start  in  1  begin a frame.
REQ-011 num_groups  in  GRP_W  number of 4-sample groups in the frame.
REQ-012 s_valid  in  1  sample group valid.
REQ-013 s_data  in  32  four unsigned 8-bit samples; [7:0] is sample 0.
REQ-014 s_ready  out  1  scheduler accepts a group.
REQ-015 rd_addr  in  log2(NUM_BINS)  accumulator read index.
REQ-016 rd_count  out  CNT_W  accumulator[rd_addr], combinational read.
REQ-017 busy  out  1  frame in progress.
REQ-018 done  out  1  one-cycle frame-complete pulse.

Function
REQ-019 States: IDLE, LOAD, SCAN, DONE; busy SHALL be 1 in LOAD and SCAN only.
REQ-020 IDLE: start=1 SHALL clear all accumulators, clear the group counter, latch num_groups, and go to LOAD; if the latched value is 0, it SHALL go to DONE instead.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 cfg_we SHALL write bounds[cfg_addr] only in IDLE or DONE; otherwise it is ignored.
REQ-023 LOAD: s_ready=1; on s_valid&s_ready, the 4 samples SHALL be registered, the bin index set to 0, and the FSM SHALL go to SCAN; s_ready SHALL be 0 in every other state.
REQ-024 SCAN: each cycle, the shared bin counter SHALL evaluate the 4 registered samples against bounds[bin index] (count 0..4 of samples with lo<=x<=hi) and add the result to accumulator[bin index].
REQ-025 lo>hi SHALL yield count 0 for that bin.
REQ-026 Accumulators SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-027 After bin NUM_BINS-1, the group counter SHALL increment; the FSM SHALL go to DONE if the count equals the latched num_groups, else to LOAD.
REQ-028 Throughput SHALL be 1+NUM_BINS cycles per group when s_valid is held high; no overlap between groups.
REQ-029 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-030 Accumulators SHALL hold their values until the next accepted start or reset; rd_count SHALL be valid in any state.
REQ-031 A sample equal to lo or hi SHALL be counted; bins MAY overlap, and a sample SHALL be counted in every bin containing it.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, s_ready 0, busy 0, done 0, all accumulators 0, group counter 0, all bounds lo=0/hi=0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; no done pulse SHALL be produced.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the sample width (8), and the samples-per-group constant (4).
REQ-035 One sub-module, hist_bin_count (combinational: 4 samples, lo, hi -> 3-bit count), SHALL be instantiated exactly once and time-shared across bins.

Verification
REQ-036 Bounds {0-3, 4-7, 8-11, 12-255}, num_groups=2, groups (0,4,1,1) and (1,12,3,11) -> counts 5, 1, 1, 1; done asserted 11 cycles after the start cycle when s_valid is always high.
REQ-037 num_groups=0 -> done pulse the cycle after start; all counts 0; s_ready never asserted.
REQ-038 Bin 0 set to lo=9, hi=2; any data -> count 0; bin 1 set to 0-255 with 1 group -> count 4.
REQ-039 CNT_W=3, bin 0-255, 2 groups -> accumulator saturates at 7, not 0.
REQ-040 s_valid deasserted for 3 cycles in LOAD -> s_ready stays high, no accumulator change; cfg_we and start pulsed while busy -> ignored.
REQ-041 rst_n pulsed low during SCAN -> all outputs and counts read 0 at once, no done pulse; a new start then runs normally.
